// File: rtl/divi_vl.sv
// rtl/divi_vl.sv - sequential signed restoring divider, one quotient bit per clock
// start/valid handshake matches the shift/add multiplier so either unit can be driven alike.
module divi_vl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dvdnd,
  input  logic [WIDTH-1:0] dvsor,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rmdr,
  output logic             valid,
  output logic             busy,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] div_reg;
  logic [CW-1:0]    cnt;
  logic             sq, sr;

  logic [WIDTH-1:0] mag_dvdnd, mag_dvsor;
  logic [WIDTH:0]   shifted, trial;
  logic             dvsor_zero;

  always_comb begin
    state_nxt  = state;
    dvsor_zero = (dvsor == '0);
    // Negating the most negative value wraps back to itself, which read unsigned is 2^(WIDTH-1).
    mag_dvdnd  = dvdnd[WIDTH-1] ? -dvdnd : dvdnd;
    mag_dvsor  = dvsor[WIDTH-1] ? -dvsor : dvsor;
    shifted    = {prem[WIDTH-1:0], q_reg[WIDTH-1]};
    trial      = shifted - {1'b0, div_reg};
    case (state)
      IDLE:    if (start) state_nxt = dvsor_zero ? DONE : CALC;
      CALC:    if (cnt == LAST) state_nxt = SIGN;
      SIGN:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg    <= '0;
      prem     <= '0;
      div_reg  <= '0;
      cnt      <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      quot     <= '0;
      rmdr     <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (dvsor_zero) begin
            quot     <= '1;
            rmdr     <= dvdnd;
            div_zero <= 1'b1;
          end else begin
            q_reg   <= mag_dvdnd;
            div_reg <= mag_dvsor;
            sq      <= dvdnd[WIDTH-1] ^ dvsor[WIDTH-1];
            sr      <= dvdnd[WIDTH-1];
            prem    <= '0;
            cnt     <= '0;
          end
        end
        CALC: begin
          // A negative trial means the divisor did not fit; keep the shifted remainder.
          if (!trial[WIDTH]) begin
            prem  <= trial;
            q_reg <= {q_reg[WIDTH-2:0], 1'b1};
          end else begin
            prem  <= shifted;
            q_reg <= {q_reg[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CW'(1);
        end
        SIGN: begin
          quot     <= sq ? -q_reg : q_reg;
          rmdr     <= sr ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          div_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign valid = (state == DONE);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_divi_vl.sv
// tb/tb_divi_vl.sv - directed and random checks for divi_vl
module tb_divi_vl;
  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset, start;
  logic [WIDTH-1:0] dvdnd, dvsor, quot, rmdr;
  logic             valid, busy, div_zero;

  int n_cmp = 0;
  int n_err = 0;

  divi_vl #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .start(start), .dvdnd(dvdnd), .dvsor(dvsor),
    .quot(quot), .rmdr(rmdr), .valid(valid), .busy(busy), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after the accepting edge; counts cycles until valid shows.
  task automatic wait_valid(output int k, output bit busy_ok);
    busy_ok = 1'b1;
    for (k = 0; k < 100; k++) begin
      if (valid) break;
      busy_ok &= busy;
      tick();
    end
    busy_ok &= busy;
  endtask

  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input logic edz, input int elat);
    int k;
    bit bok;
    dvdnd = a; dvsor = b; start = 1'b1;
    tick();
    start = 1'b0; dvdnd = $urandom; dvsor = $urandom;
    wait_valid(k, bok);
    chk({tag, " latency"}, k, elat);
    chk({tag, " quot"}, quot, eq);
    chk({tag, " rmdr"}, rmdr, er);
    chk({tag, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
    chk({tag, " busy span"}, {31'd0, bok}, 32'd1);
    tick();
    chk({tag, " valid width"}, {31'd0, valid}, 32'd0);
    chk({tag, " busy after"}, {31'd0, busy}, 32'd0);
    chk({tag, " quot hold"}, quot, eq);
  endtask

  initial begin
    int k;
    bit bok, seen;
    int ca, cb;
    longint la, lb;

    reset = 1'b1; start = 1'b0; dvdnd = '0; dvsor = '0;
    tick(); tick();
    chk("reset quot", quot, 32'd0);
    chk("reset rmdr", rmdr, 32'd0);
    chk("reset valid", {31'd0, valid}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;
    tick();

    do_div("100/7",   32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
    do_div("-100/7",  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33);
    do_div("100/-7",  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33);
    do_div("-100/-7", 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33);
    do_div("min/-1",  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33);
    do_div("max/1",   32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0, 33);
    do_div("3/10",    32'd3,          32'd10,         32'd0,          32'd3,          1'b0, 33);
    do_div("5/0",     32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 0);
    do_div("after dz",32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);

    // start while busy is ignored
    dvdnd = 32'd1000; dvsor = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    dvdnd = 32'd8; dvsor = 32'd2; start = 1'b1;
    tick();
    start = 1'b0; dvdnd = 32'd77;
    wait_valid(k, bok);
    chk("ignore latency", k, 32'd23);
    chk("ignore quot", quot, 32'd333);
    chk("ignore rmdr", rmdr, 32'd1);
    tick(); tick();
    chk("ignore no requeue", {31'd0, busy}, 32'd0);

    // reset mid-calculation
    dvdnd = 32'd1000; dvsor = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    #2 reset = 1'b1;
    #1;
    chk("midreset quot", quot, 32'd0);
    chk("midreset rmdr", rmdr, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset valid", {31'd0, valid}, 32'd0);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen |= valid;
    end
    chk("midreset no valid", {31'd0, seen}, 32'd0);
    do_div("post reset", 32'd1000, 32'd7, 32'd142, 32'd6, 1'b0, 33);

    // back-to-back random with start held high
    ca = -123456; cb = 789;
    dvdnd = ca; dvsor = cb; start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      wait_valid(k, bok);
      la = longint'(ca); lb = longint'(cb);
      chk("rand latency", k, 32'd33);
      chk("rand quot", quot, 32'(la / lb));
      chk("rand rmdr", rmdr, 32'(la % lb));
      if (i < 7) begin
        ca = $urandom;
        cb = int'($urandom >> $urandom_range(0, 31));
        if ($urandom_range(0, 1) == 1) cb = -cb;
        if (cb == 0) cb = 1;
        if (ca == 32'h80000000 && cb == -1) cb = 3;
        dvdnd = ca; dvsor = cb;
      end else begin
        start = 1'b0;
      end
      tick();
      chk("rand valid width", {31'd0, valid}, 32'd0);
      tick();
    end
    chk("rand end idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/divi_vl.md
# divi_vl

Sequential signed integer divider. It takes a two's-complement dividend and divisor on a start pulse and produces quotient and remainder after a fixed iterative latency, one quotient bit per clock. It is the inverse-operation companion to the sequential shift/add multiplier in the arithmetic library and uses the same start/valid handshake style, so control logic can drive either unit interchangeably.

## Interface
- WIDTH, 32, operand width in bits (quotient and remainder have the same width)
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dvdnd  input  WIDTH  signed dividend; captured on accepted start
- dvsor  input  WIDTH  signed divisor; captured on accepted start
- quot  output  WIDTH  signed quotient; registered, holds until next result
- rmdr  output  WIDTH  signed remainder; registered, holds until next result
- valid  output  1  one-cycle pulse; quot/rmdr/div_zero are new this cycle
- busy  output  1  high whenever state is not IDLE
- div_zero  output  1  result flag; divisor was zero; valid with valid

## Operation
- States: IDLE, CALC, SIGN, DONE.
- IDLE, start=1, dvsor≠0:
  - capture |dvdnd| into the quotient shift register and |dvsor| into the divisor register (magnitudes as unsigned WIDTH bits; -2^(WIDTH-1) maps to 2^(WIDTH-1));
  - store sign bits sq = dvdnd[MSB]^dvsor[MSB] and sr = dvdnd[MSB];
  - clear the WIDTH+1-bit partial remainder and the iteration counter;
  - go to CALC.
- IDLE, start=1, dvsor=0: quot←all ones, rmdr←dvdnd (unmodified), div_zero←1; go to DONE.
- CALC (restoring division, one step per cycle): shift {prem, q} left 1; trial = prem − divisor in WIDTH+1 bits.
  - trial non-negative: prem←trial, q[0]←1.
  - otherwise: q[0]←0, prem unchanged.
  - Counter increments each step; after the WIDTH-th step go to SIGN.
- SIGN:
  - quot←sq ? −q : q;
  - rmdr←sr ? −prem[WIDTH-1:0] : prem[WIDTH-1:0];
  - div_zero←0; go to DONE.
- DONE: valid=1 for this cycle only; go to IDLE unconditionally.
- Semantics:
  - quotient truncates toward zero; nonzero remainder carries the dividend's sign; |rmdr| < |dvsor|;
  - −2^(WIDTH-1) / −1 yields quot=0x80000000, rmdr=0 (wraps, no flag).
- start outside IDLE is ignored (including the DONE cycle); no queueing.
- Input ports are don't-care after the accepting edge.

## Timing
- Reset, asynchronous: state=IDLE, quot=0, rmdr=0, valid=0, div_zero=0, busy=0, internal registers cleared. Reset mid-CALC aborts with no valid pulse.
- Normal op: start accepted at edge N; CALC steps at edges N+1..N+WIDTH; SIGN writes outputs at edge N+WIDTH+1; valid high from edge N+WIDTH+1 to N+WIDTH+2 (33 edges for WIDTH=32).
- Divide by zero: outputs written at edge N; valid high from edge N to N+1.
- busy rises at edge N and falls when DONE exits to IDLE. Earliest next accept: edge N+WIDTH+3 (normal) or N+2 (div-by-zero).
- Sustained throughput: one result per WIDTH+3 cycles.
- quot/rmdr/div_zero change only on the output-writing edge and otherwise hold. valid is never high for two consecutive cycles.

## Test plan
- 100 / 7 → quot=14, rmdr=2, div_zero=0; valid exactly 33 cycles after the start edge, one cycle wide; busy high over the same span.
- −100 / 7 → quot=0xFFFFFFF2, rmdr=0xFFFFFFFE; 100 / −7 → quot=0xFFFFFFF2, rmdr=2; −100 / −7 → quot=14, rmdr=0xFFFFFFFE.
- 0x80000000 / 0xFFFFFFFF → quot=0x80000000, rmdr=0. 0x7FFFFFFF / 1 → quot=0x7FFFFFFF, rmdr=0. 3 / 10 → quot=0, rmdr=3.
- 5 / 0 → quot=0xFFFFFFFF, rmdr=5, div_zero=1, valid one cycle after the start edge. The next normal divide clears div_zero.
- Start 1000 / 3, pulse start with 8 / 2 at cycle 10 and change dvdnd → ignored; result 333 / 1.
- Reset asserted at cycle 20 of a divide → all outputs 0, no valid; the next start completes normally.
- Random signed pairs, back-to-back with start held high → each result matches the truncating reference model, one valid per WIDTH+3 cycles.
